// File: rtl/serdes_pkg.sv
// Shared helpers for the serializer/deserializer pair.
// Holds the width-derivation function both ends use to size their bit counters.
package serdes_pkg;

  // Bit counter width for a word of 'width' bits; never narrower than 1.
  function automatic int cntr_bits(input int width);
    int c;
    c = $clog2(width);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/deserializer_if.sv
// Serial-in / parallel-out bus of the deserializer.
// The master modport belongs to the serial source plus word consumer; the slave modport belongs to the deserializer.
interface deserializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_valid;
  logic                  i_data;
  logic                  i_ready;
  logic                  i_clr_err;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  o_busy;
  logic                  o_overrun;
  logic                  o_frame_err;

  modport master (
    output i_valid, i_data, i_ready, i_clr_err,
    input  o_data, o_valid, o_busy, o_overrun, o_frame_err
  );

  modport slave (
    input  i_valid, i_data, i_ready, i_clr_err,
    output o_data, o_valid, o_busy, o_overrun, o_frame_err
  );
endinterface

// File: rtl/deserializer.sv
// Reassembles an LSB-first, valid-qualified serial stream into DATA_WIDTH-bit words
// presented on a valid/ready output register, with sticky overrun and framing flags.
module deserializer
  import serdes_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input logic           i_clk,
  input logic           i_rst,
  deserializer_if.slave bus
);

  localparam int CNTR_BITS = cntr_bits(DATA_WIDTH);
  localparam logic [CNTR_BITS-1:0] LAST_BIT = CNTR_BITS'(DATA_WIDTH - 1);

  // The top bit never needs storing: it arrives on the completing edge itself.
  logic [DATA_WIDTH-2:0] shift_reg;
  logic [CNTR_BITS-1:0]  cnt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  overrun_q;
  logic                  frame_err_q;

  logic word_done;
  logic can_load;
  logic frame_break;

  assign word_done   = bus.i_valid && (cnt == LAST_BIT);
  assign can_load    = !valid_q || bus.i_ready;
  assign frame_break = !bus.i_valid && (cnt != '0);

  // NOTE: all state below is updated with non-blocking assignments so every
  // branch sees the pre-edge value of cnt/valid_q, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shift_reg   <= '0;
      cnt         <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (bus.i_valid) begin
        for (int k = 0; k < DATA_WIDTH - 1; k++) begin
          if (cnt == CNTR_BITS'(k)) shift_reg[k] <= bus.i_data;
        end
        cnt <= word_done ? '0 : cnt + CNTR_BITS'(1);
      end else if (frame_break) begin
        cnt <= '0;
      end

      if (word_done && can_load) begin
        data_q  <= {bus.i_data, shift_reg};
        valid_q <= 1'b1;
      end else if (valid_q && bus.i_ready) begin
        valid_q <= 1'b0;
      end

      // A new error event in the clearing cycle wins over the clear.
      if (word_done && !can_load) overrun_q <= 1'b1;
      else if (bus.i_clr_err)     overrun_q <= 1'b0;

      if (frame_break)            frame_err_q <= 1'b1;
      else if (bus.i_clr_err)     frame_err_q <= 1'b0;
    end
  end

  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_busy      = (cnt != '0);
  assign bus.o_overrun   = overrun_q;
  assign bus.o_frame_err = frame_err_q;

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive-side neighbour of the serializer.
- Samples a 1-bit stream qualified by a valid strobe, LSB first, and reassembles DATA_WIDTH-bit words.
- Presents each word on a valid/ready parallel output.
- Connects directly to the serializer: its o_data drives i_data and its o_busy drives i_valid. Framing and overrun errors are reported as sticky flags.

Parameters:
- DATA_WIDTH, 8, word width in bits; legal range 2 or more. Must match the upstream serializer.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge
- i_rst  input  1  reset; asynchronous, active-high
- i_valid  input  1  serial bit strobe; i_data is sampled only when high
- i_data  input  1  serial data bit, LSB of the word first
- o_data  output  DATA_WIDTH  assembled word; stable while o_valid is high
- o_valid  output  1  o_data holds an unconsumed word
- i_ready  input  1  consumer accepts o_data when o_valid and i_ready are both high
- o_busy  output  1  partial word in progress (bit count nonzero)
- o_overrun  output  1  sticky: a completed word was dropped because the output register was full
- o_frame_err  output  1  sticky: i_valid dropped before a word was complete
- i_clr_err  input  1  synchronous clear of o_overrun and o_frame_err

Behaviour:
- Reset (asynchronous, any time, including mid-word):
  - shift register, bit counter, o_data, o_valid, o_overrun and o_frame_err all go to 0; o_busy goes to 0.
  - Any partial word is discarded. No flag is raised because of the reset.
- Counter:
  - CNTR_BITS = $clog2(DATA_WIDTH), minimum 1.
  - cnt counts bits received in the current word, 0..DATA_WIDTH-1.
  - o_busy = (cnt != 0), driven combinationally from the register.
- Shift, on each edge with i_valid=1:
  - shift_reg[cnt] <= i_data, so bit k of the word is the k-th sampled bit.
  - If cnt == DATA_WIDTH-1, the word completes: cnt <= 0. Otherwise cnt <= cnt+1.
- Completion. The completed word is {i_data, shift_reg[DATA_WIDTH-2:0]}, i.e. it includes the current bit.
  - If o_valid=0, or o_valid=1 with i_ready=1 in the same cycle: o_data <= word and o_valid <= 1. This latches on the same edge as the last bit, so latency is 0 cycles after the final sampled bit and o_valid is visible the following cycle.
  - If o_valid=1 and i_ready=0: the new word is dropped, o_data is unchanged, and o_overrun <= 1.
- Output handshake:
  - If o_valid and i_ready are high and no word completes, o_valid <= 0.
  - o_data is not modified while o_valid=1 except on a simultaneous accept-and-complete, which reloads it.
- Framing:
  - An edge with i_valid=0 and cnt != 0 sets o_frame_err <= 1 and cnt <= 0. The partial word is discarded.
  - i_valid=0 with cnt=0 is idle; nothing changes.
- Back-to-back words:
  - Continuous i_valid across word boundaries is legal. The count wraps and the next word starts immediately.
  - Gaps between words (the serializer inserts at least 1 idle cycle) are legal.
- Error clear:
  - i_clr_err=1 clears both flags on the next edge.
  - If a new error event occurs in the same cycle as i_clr_err, the flag is set (set wins).
- i_data is don't-care when i_valid=0.
- The block never stalls its input; there is no backpressure to the serial side.

Decomposition:
- No typedefs are required.
- CNTR_BITS is a local parameter computed in the module.
- A shared serdes_pkg holds the common width-derivation function used by both the serializer and the deserializer: cntr_bits(width) = max(1, $clog2(width)).
- No sub-module; the block is a single module (shift/count datapath plus output register).

Test Plan (DATA_WIDTH=8):
- Word assembly: drive bits 1,0,1,0,0,1,0,1 with i_valid=1 for 8 cycles, i_ready=1 -> o_valid=1 for exactly 1 cycle with o_data=0xA5. o_busy is high from cycle 2 through cycle 8 of the stream.
- Backpressure and overrun: i_ready=0, send 0x3C then 0xF0 back-to-back -> o_data stays 0x3C and o_valid stays 1. o_overrun=1 after the 16th bit. Raising i_ready consumes 0x3C, then o_valid=0.
- Simultaneous accept and complete: o_valid=1 holding 0x11, i_ready=1 on the same edge 0x22 completes -> o_valid stays 1, o_data=0x22, o_overrun stays 0.
- Framing error: 5 bits with i_valid=1, then i_valid=0 -> o_frame_err=1, o_busy=0. A following full word 0x7E is received correctly. i_clr_err clears the flag next edge.
- Reset mid-word: assert i_rst after 3 bits -> all outputs 0 immediately. After release, a full word 0x81 is received correctly with no flags set.
- Loopback: serializer to deserializer with random words and random consumer i_ready held high -> every written word is reproduced in order and no flags are set.
